// File: rtl/dmem_responder.sv
// Data-memory responder: 64x32 word store behind a wait-state FSM with a one-cycle ack pulse.
// Define DMEM_WAIT_EN for three wait states (5-cycle latency); undefined gives 2-cycle latency.
module dmem_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic        BEDmemM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemAckM,
  output logic        MemErrM,
  output logic        StallM
);

`ifdef DMEM_WAIT_EN
  localparam int CW = 2;
  localparam logic [CW-1:0] WAIT_LOAD = 2'd3;
`else
  localparam int CW = 1;
  localparam logic [CW-1:0] WAIT_LOAD = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} stateT;

  stateT         stateReg, stateNext;
  logic [CW-1:0] counterReg, counterNext;
  logic          doAccess;

  logic [31:0] memArray [64];
  logic [5:0]  wordIdx;
  logic [1:0]  lane;
  logic        misaligned;
  logic        memWrite;
  logic [3:0]  byteEn;
  logic [31:0] wrData;
  logic [31:0] rdWord;
  logic [7:0]  rdByte;
  logic [31:0] rdData;
  logic        unusedAddrBits;

  assign wordIdx        = ALUResultM[7:2];
  assign lane           = ALUResultM[1:0];
  assign unusedAddrBits = ^ALUResultM[31:8];
  assign misaligned     = ~BEDmemM & (lane != 2'b00);

  always_comb begin
    stateNext   = stateReg;
    counterNext = counterReg;
    doAccess    = 1'b0;
    unique case (stateReg)
      IDLE: begin
        if (MemReqM) begin
          stateNext   = ACCESS;
          counterNext = WAIT_LOAD;
        end
      end
      ACCESS: begin
        // A withdrawn request abandons the access before anything is committed.
        if (!MemReqM) begin
          stateNext   = IDLE;
          counterNext = '0;
        end else if (counterReg != '0) begin
          counterNext = counterReg - CW'(1);
        end else begin
          stateNext = RESP;
          doAccess  = 1'b1;
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign memWrite = doAccess & MemWriteM & ~misaligned;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : genLane
      assign byteEn[gi]           = memWrite & (~BEDmemM | (lane == 2'(gi)));
      assign wrData[gi*8 +: 8]    = BEDmemM ? WriteDataM[7:0] : WriteDataM[gi*8 +: 8];
    end
  endgenerate

  // Storage is never reset; contents survive reset and power up undefined.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (byteEn[i]) memArray[wordIdx][i*8 +: 8] <= wrData[i*8 +: 8];
    end
  end

  assign rdWord = memArray[wordIdx];
  assign rdByte = rdWord[{lane, 3'b000} +: 8];

  always_comb begin
    rdData = '0;
    if (!MemWriteM && !misaligned) rdData = BEDmemM ? {24'h0, rdByte} : rdWord;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg   <= IDLE;
      counterReg <= '0;
      ReadDataM  <= '0;
      MemErrM    <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      counterReg <= counterNext;
      if (doAccess) begin
        ReadDataM <= rdData;
        MemErrM   <= misaligned;
      end
    end
  end

  assign MemAckM = (stateReg == RESP);
  assign StallM  = MemReqM & ~MemAckM;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: behavioural memory model plus per-cycle output checker.
module tb_dmem_responder;

`ifdef DMEM_WAIT_EN
  localparam int W = 3;
`else
  localparam int W = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemReqM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic        BEDmemM = 1'b0;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic [31:0] ReadDataM;
  logic        MemAckM;
  logic        MemErrM;
  logic        StallM;

  dmem_responder dut (
    .clk(clk), .reset(reset), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
    .BEDmemM(BEDmemM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .MemAckM(MemAckM), .MemErrM(MemErrM), .StallM(StallM)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: word array plus the cycle on which the pending ack is due.
  logic [31:0] modelMem [64];
  int          expAckAt = -1;
  logic [31:0] expRd = '0;
  logic        expErr = 1'b0;

  logic [31:0] gotRd;
  logic        gotErr;
  int          gotLat;

  always @(negedge clk) begin
    bit ackExp;
    if (!reset) begin
      chk("rst_ack", 32'(MemAckM), 32'd0);
      chk("rst_rd", ReadDataM, 32'd0);
      chk("rst_err", 32'(MemErrM), 32'd0);
      chk("rst_stall", 32'(StallM), 32'(MemReqM));
    end else begin
      ackExp = (cyc == expAckAt);
      chk("ack", 32'(MemAckM), 32'(ackExp));
      chk("stall", 32'(StallM), 32'(MemReqM & ~ackExp));
      if (ackExp) begin
        chk("rdata", ReadDataM, expRd);
        chk("err", 32'(MemErrM), 32'(expErr));
      end
    end
  end

  // Drives a request and returns just after the ack-cycle negedge with MemReqM still high.
  // chain=1 means the previous request is still held through its RESP cycle.
  task automatic txn(input logic w, input logic b, input logic [31:0] a,
                     input logic [31:0] d, input bit chain);
    int idx, ln, c;
    bit mis;
    logic [31:0] rd;
    idx = int'(a[7:2]);
    ln  = int'(a[1:0]);
    mis = !b && (a[1:0] != 2'b00);
    rd  = '0;
    if (!w && !mis) rd = b ? {24'h0, modelMem[idx][ln*8 +: 8]} : modelMem[idx];
    if (w && !mis) begin
      if (b) modelMem[idx][ln*8 +: 8] = d[7:0];
      else   modelMem[idx] = d;
    end
    MemWriteM  = w;
    BEDmemM    = b;
    ALUResultM = a;
    WriteDataM = d;
    MemReqM    = 1'b1;
    expRd      = rd;
    expErr     = mis;
    c          = cyc;
    expAckAt   = chain ? cyc + W + 3 : cyc + W + 2;
    gotLat     = -1;
    for (int k = 0; k < W + 12; k++) begin
      @(negedge clk);
      if (MemAckM) begin
        gotLat = cyc - c;
        break;
      end
    end
    if (gotLat < 0) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: got no ack expected ack at cycle %0d", expAckAt);
    end
    gotRd  = ReadDataM;
    gotErr = MemErrM;
    #1;
  endtask

  task automatic rel();
    @(posedge clk);
    #1;
    MemReqM = 1'b0;
  endtask

  // Request withdrawn after k edges while still in ACCESS: no ack, no write.
  task automatic abortTxn(input logic w, input logic b, input logic [31:0] a,
                          input logic [31:0] d, input int k);
    expAckAt   = -1;
    MemWriteM  = w;
    BEDmemM    = b;
    ALUResultM = a;
    WriteDataM = d;
    MemReqM    = 1'b1;
    repeat (k) @(posedge clk);
    #1;
    MemReqM = 1'b0;
    repeat (W + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic w, b;
    logic [31:0] a, d;
    bit pending;
    int mode;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 64; i++) begin
      txn(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b0);
      rel();
    end

    // Directed cases with hand-computed results.
    txn(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    chk("lit_lat_store", 32'(gotLat), 32'(W + 2));
    chk("lit_err_store", 32'(gotErr), 32'd0);
    rel();
    txn(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("lit_load10", gotRd, 32'hDEADBEEF);
    chk("lit_lat_load", 32'(gotLat), 32'(W + 2));
    rel();
    txn(1'b1, 1'b1, 32'h12, 32'h55, 1'b0);
    rel();
    txn(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("lit_bytemerge", gotRd, 32'hDE55BEEF);
    rel();
    txn(1'b0, 1'b1, 32'h13, 32'h0, 1'b0);
    chk("lit_byteload", gotRd, 32'h000000DE);
    rel();
    txn(1'b1, 1'b0, 32'h20, 32'hCAFEF00D, 1'b0);
    rel();
    txn(1'b1, 1'b0, 32'h21, 32'h12345678, 1'b0);
    chk("lit_mis_err", 32'(gotErr), 32'd1);
    chk("lit_mis_rd", gotRd, 32'd0);
    rel();
    txn(1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
    chk("lit_mis_nowrite", gotRd, 32'hCAFEF00D);
    rel();
    txn(1'b1, 1'b0, 32'h00000104, 32'hA5A5A5A5, 1'b0);
    rel();
    txn(1'b0, 1'b0, 32'h04, 32'h0, 1'b0);
    chk("lit_wrap", gotRd, 32'hA5A5A5A5);

    // Reset asynchronously in the middle of the RESP cycle.
    reset = 1'b0;
    expAckAt = -1;
    #1;
    chk("async_rst_ack", 32'(MemAckM), 32'd0);
    chk("async_rst_rd", ReadDataM, 32'd0);
    MemReqM = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset during ACCESS of a store must drop the store.
    txn(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    rel();
    expAckAt   = -1;
    MemWriteM  = 1'b1;
    BEDmemM    = 1'b0;
    ALUResultM = 32'h30;
    WriteDataM = 32'h11111111;
    MemReqM    = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("access_rst_rd", ReadDataM, 32'd0);
    chk("access_rst_ack", 32'(MemAckM), 32'd0);
    MemReqM = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    txn(1'b0, 1'b0, 32'h30, 32'h0, 1'b0);
    chk("lit_rst_nowrite", gotRd, 32'h0);
    rel();

    abortTxn(1'b1, 1'b0, 32'h30, 32'h77777777, (W == 3) ? 2 : 1);
    chk("abort_stall", 32'(StallM), 32'd0);
    txn(1'b0, 1'b0, 32'h30, 32'h0, 1'b0);
    chk("lit_abort_nowrite", gotRd, 32'h0);
    rel();

    // Randomised traffic with chained requests, gaps and aborts.
    pending = 1'b0;
    for (int n = 0; n < 250; n++) begin
      mode = int'($urandom_range(0, 9));
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      a = $urandom;
      d = $urandom;
      if (!b && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if (pending && mode >= 6) begin
        txn(w, b, a, d, 1'b1);
      end else begin
        if (pending) begin
          rel();
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        if (mode == 0) begin
          abortTxn(w, b, a, d, int'($urandom_range(1, W + 1)));
          pending = 1'b0;
          continue;
        end
        txn(w, b, a, d, 1'b0);
      end
      pending = 1'b1;
    end
    if (pending) rel();
    repeat (4) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
